// File: rtl/gpio_arb_pkg24.sv
// rtl/gpio_arb_pkg24.sv - shared types and constants for the GPIO APB arbiter
package gpio_arb_pkg24;

  // APB transfer sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Requester identities; the ID doubles as the grant bit index
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_PM  = 1'b1;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/rr_arb2_24.sv
// rtl/rr_arb2_24.sv - two-input round-robin arbiter with favoured-requester pointer
module rr_arb2_24
  import gpio_arb_pkg24::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // Favoured requester wins a tie; a lone requester always wins
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (ptr == REQ_PM) ? 2'b10 : 2'b01;
    end
  end

  // After a grant the other requester becomes favoured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ_CPU;
    end else if (advance) begin
      ptr <= ~grant[1];
    end
  end

endmodule

// File: rtl/gpio_apb_arb24.sv
// rtl/gpio_apb_arb24.sv - arbitrates two requesters onto the GPIO APB slave port
module gpio_apb_arb24
  import gpio_arb_pkg24::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              pclk24,
  input  logic              n_p_reset24,
  input  logic              req0_valid24,
  input  logic              req0_write24,
  input  logic [ADDR_W-1:0] req0_addr24,
  input  logic [DATA_W-1:0] req0_wdata24,
  input  logic              req1_valid24,
  input  logic              req1_write24,
  input  logic [ADDR_W-1:0] req1_addr24,
  input  logic [DATA_W-1:0] req1_wdata24,
  output logic              req0_ready24,
  output logic              req1_ready24,
  output logic              req0_rvalid24,
  output logic              req1_rvalid24,
  output logic [DATA_W-1:0] req_rdata24,
  output logic              psel24,
  output logic              penable24,
  output logic              pwrite24,
  output logic [ADDR_W-1:0] paddr24,
  output logic [DATA_W-1:0] pwdata24,
  input  logic [DATA_W-1:0] prdata24,
  output logic              busy24
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        grant;
  logic              accepting;
  logic              accept;
  logic              win_id;
  logic              rid;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;

  rr_arb2_24 u_arb (
    .clk     (pclk24),
    .rst_n   (n_p_reset24),
    .valid   ({req1_valid24, req0_valid24}),
    .advance (accept),
    .grant   (grant)
  );

  // Commands are taken only when the APB port is free or finishing; ready is held low in reset
  always_comb begin
    accepting    = (state == ST_IDLE) || (state == ST_ACCESS);
    req0_ready24 = accepting && n_p_reset24 && grant[0];
    req1_ready24 = accepting && n_p_reset24 && grant[1];
    accept       = req0_ready24 || req1_ready24;
    win_id       = grant[1];
  end

  // Sequencer: IDLE -> SETUP -> ACCESS, chaining straight into SETUP when a new command is taken
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = accept ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = accept ? ST_SETUP : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register plus command latch of the winning requester
  always_ff @(posedge pclk24 or negedge n_p_reset24) begin
    if (!n_p_reset24) begin
      state    <= ST_IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rid      <= REQ_CPU;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rid      <= win_id;
        pwrite_q <= (win_id == REQ_PM) ? req1_write24 : req0_write24;
        paddr_q  <= (win_id == REQ_PM) ? req1_addr24  : req0_addr24;
        pwdata_q <= (win_id == REQ_PM) ? req1_wdata24 : req0_wdata24;
      end
    end
  end

  // Read return: capture prdata at the end of a read ACCESS and pulse the issuer's rvalid
  always_ff @(posedge pclk24 or negedge n_p_reset24) begin
    if (!n_p_reset24) begin
      req_rdata24   <= '0;
      req0_rvalid24 <= 1'b0;
      req1_rvalid24 <= 1'b0;
    end else begin
      req0_rvalid24 <= 1'b0;
      req1_rvalid24 <= 1'b0;
      if (state == ST_ACCESS && !pwrite_q) begin
        req_rdata24   <= prdata24;
        req0_rvalid24 <= (rid == REQ_CPU);
        req1_rvalid24 <= (rid == REQ_PM);
      end
    end
  end

  // APB phase decode straight from state so reset clears the strobes immediately
  always_comb begin
    psel24    = (state != ST_IDLE);
    penable24 = (state == ST_ACCESS);
    busy24    = (state != ST_IDLE);
    pwrite24  = pwrite_q;
    paddr24   = paddr_q;
    pwdata24  = pwdata_q;
  end

endmodule

// File: tb/tb_gpio_apb_arb24.sv
// tb/tb_gpio_apb_arb24.sv - directed vector bench for gpio_apb_arb24
module tb_gpio_apb_arb24;

  logic        pclk24;
  logic        n_p_reset24;
  logic        req0_valid24, req0_write24, req1_valid24, req1_write24;
  logic [5:0]  req0_addr24, req1_addr24;
  logic [31:0] req0_wdata24, req1_wdata24;
  logic        req0_ready24, req1_ready24, req0_rvalid24, req1_rvalid24;
  logic [31:0] req_rdata24;
  logic        psel24, penable24, pwrite24, busy24;
  logic [5:0]  paddr24;
  logic [31:0] pwdata24, prdata24;

  int checks = 0;
  int errors = 0;

  gpio_apb_arb24 dut (
    .pclk24        (pclk24),
    .n_p_reset24   (n_p_reset24),
    .req0_valid24  (req0_valid24),
    .req0_write24  (req0_write24),
    .req0_addr24   (req0_addr24),
    .req0_wdata24  (req0_wdata24),
    .req1_valid24  (req1_valid24),
    .req1_write24  (req1_write24),
    .req1_addr24   (req1_addr24),
    .req1_wdata24  (req1_wdata24),
    .req0_ready24  (req0_ready24),
    .req1_ready24  (req1_ready24),
    .req0_rvalid24 (req0_rvalid24),
    .req1_rvalid24 (req1_rvalid24),
    .req_rdata24   (req_rdata24),
    .psel24        (psel24),
    .penable24     (penable24),
    .pwrite24      (pwrite24),
    .paddr24       (paddr24),
    .pwdata24      (pwdata24),
    .prdata24      (prdata24),
    .busy24        (busy24)
  );

  initial pclk24 = 1'b0;
  always #5 pclk24 = ~pclk24;

  typedef struct {
    logic        v0, w0;
    logic [5:0]  a0;
    logic [31:0] d0;
    logic        v1, w1;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic [31:0] prd;
    logic        rdy0, rdy1, psel, pen, pwr;
    logic [5:0]  paddr;
    logic [31:0] pwdata;
    logic        rv0, rv1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(
    logic v0, logic w0, logic [5:0] a0, logic [31:0] d0,
    logic v1, logic w1, logic [5:0] a1, logic [31:0] d1, logic [31:0] prd,
    logic rdy0, logic rdy1, logic psel, logic pen, logic pwr,
    logic [5:0] paddr, logic [31:0] pwdata, logic rv0, logic rv1, logic [31:0] rdata);
    vec_t r;
    r.v0 = v0; r.w0 = w0; r.a0 = a0; r.d0 = d0;
    r.v1 = v1; r.w1 = w1; r.a1 = a1; r.d1 = d1; r.prd = prd;
    r.rdy0 = rdy0; r.rdy1 = rdy1; r.psel = psel; r.pen = pen; r.pwr = pwr;
    r.paddr = paddr; r.pwdata = pwdata; r.rv0 = rv0; r.rv1 = rv1; r.rdata = rdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [5:0] a0, input logic [31:0] d0,
                       input logic v1, input logic w1, input logic [5:0] a1, input logic [31:0] d1,
                       input logic [31:0] prd);
    req0_valid24 = v0; req0_write24 = w0; req0_addr24 = a0; req0_wdata24 = d0;
    req1_valid24 = v1; req1_write24 = w1; req1_addr24 = a1; req1_wdata24 = d1;
    prdata24 = prd;
  endtask

  task automatic chk_apb(input string tag, input logic psel, input logic pen);
    chk({tag, ".psel"}, psel24, psel);
    chk({tag, ".penable"}, penable24, pen);
    chk({tag, ".busy"}, busy24, psel);
  endtask

  initial begin
    // Write, read, contention, single-requester streaming; one row per clock cycle
    vecs[0]  = mk(1,1,6'h04,32'hFF, 0,0,6'h00,0, 0,           1,0,0,0,0,6'h04-6'h04,0,0,0,0);
    vecs[1]  = mk(0,0,0,0, 0,0,0,0, 0,                       0,0,1,0,1,6'h04,32'hFF,0,0,0);
    vecs[2]  = mk(0,0,0,0, 0,0,0,0, 32'h77,                  0,0,1,1,1,6'h04,32'hFF,0,0,0);
    vecs[3]  = mk(0,0,0,0, 0,0,0,0, 0,                       0,0,0,0,1,6'h04,32'hFF,0,0,0);
    vecs[4]  = mk(0,0,0,0, 1,0,6'h08,0, 0,                   0,1,0,0,1,6'h04,32'hFF,0,0,0);
    vecs[5]  = mk(0,0,0,0, 0,0,0,0, 0,                       0,0,1,0,0,6'h08,0,0,0,0);
    vecs[6]  = mk(0,0,0,0, 0,0,0,0, 32'hA5A5,                0,0,1,1,0,6'h08,0,0,0,0);
    vecs[7]  = mk(0,0,0,0, 0,0,0,0, 0,                       0,0,0,0,0,6'h08,0,0,1,32'hA5A5);
    vecs[8]  = mk(0,0,0,0, 0,0,0,0, 0,                       0,0,0,0,0,6'h08,0,0,0,32'hA5A5);
    vecs[9]  = mk(1,1,6'h10,32'h11, 1,0,6'h20,0, 0,          1,0,0,0,0,6'h08,0,0,0,32'hA5A5);
    vecs[10] = mk(1,1,6'h14,32'h22, 1,0,6'h20,0, 0,          0,0,1,0,1,6'h10,32'h11,0,0,32'hA5A5);
    vecs[11] = mk(1,1,6'h14,32'h22, 1,0,6'h20,0, 0,          0,1,1,1,1,6'h10,32'h11,0,0,32'hA5A5);
    vecs[12] = mk(1,1,6'h14,32'h22, 1,0,6'h24,0, 0,          0,0,1,0,0,6'h20,0,0,0,32'hA5A5);
    vecs[13] = mk(1,1,6'h14,32'h22, 1,0,6'h24,0, 32'hCAFE0001, 1,0,1,1,0,6'h20,0,0,0,32'hA5A5);
    vecs[14] = mk(0,0,0,0, 1,0,6'h24,0, 0,                   0,0,1,0,1,6'h14,32'h22,0,1,32'hCAFE0001);
    vecs[15] = mk(0,0,0,0, 1,0,6'h24,0, 32'hDEAD0000,        0,1,1,1,1,6'h14,32'h22,0,0,32'hCAFE0001);
    vecs[16] = mk(0,0,0,0, 0,0,0,0, 0,                       0,0,1,0,0,6'h24,0,0,0,32'hCAFE0001);
    vecs[17] = mk(0,0,0,0, 0,0,0,0, 32'hBEEF0002,            0,0,1,1,0,6'h24,0,0,0,32'hCAFE0001);
    vecs[18] = mk(0,0,0,0, 0,0,0,0, 0,                       0,0,0,0,0,6'h24,0,0,1,32'hBEEF0002);
    vecs[19] = mk(0,0,0,0, 1,0,6'h30,0, 0,                   0,1,0,0,0,6'h24,0,0,0,32'hBEEF0002);
    vecs[20] = mk(0,0,0,0, 1,0,6'h34,0, 0,                   0,0,1,0,0,6'h30,0,0,0,32'hBEEF0002);
    vecs[21] = mk(0,0,0,0, 1,0,6'h34,0, 32'h101,             0,1,1,1,0,6'h30,0,0,0,32'hBEEF0002);
    vecs[22] = mk(0,0,0,0, 1,0,6'h38,0, 0,                   0,0,1,0,0,6'h34,0,0,1,32'h101);
    vecs[23] = mk(0,0,0,0, 1,0,6'h38,0, 32'h102,             0,1,1,1,0,6'h34,0,0,0,32'h101);
    vecs[24] = mk(0,0,0,0, 0,0,0,0, 0,                       0,0,1,0,0,6'h38,0,0,1,32'h102);
    vecs[25] = mk(0,0,0,0, 0,0,0,0, 32'h103,                 0,0,1,1,0,6'h38,0,0,0,32'h102);
    vecs[26] = mk(0,0,0,0, 0,0,0,0, 0,                       0,0,0,0,0,6'h38,0,0,1,32'h103);

    // Reset state, with both requesters asking: no ready may leak through
    n_p_reset24 = 1'b0;
    drive(1,1,6'h01,32'h1, 1,0,6'h02,32'h2, 32'h0);
    repeat (2) @(posedge pclk24);
    @(negedge pclk24);
    chk_apb("rst", 1'b0, 1'b0);
    chk("rst.ready0", req0_ready24, 1'b0);
    chk("rst.ready1", req1_ready24, 1'b0);
    chk("rst.rvalid0", req0_rvalid24, 1'b0);
    chk("rst.rvalid1", req1_rvalid24, 1'b0);
    chk("rst.pwrite", pwrite24, 1'b0);
    chk("rst.paddr", paddr24, 6'h00);
    chk("rst.pwdata", pwdata24, 32'h0);
    chk("rst.rdata", req_rdata24, 32'h0);
    drive(0,0,0,0, 0,0,0,0, 0);
    @(posedge pclk24);
    #1 n_p_reset24 = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(posedge pclk24);
      #1 drive(vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
               vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1, vecs[i].prd);
      @(negedge pclk24);
      chk($sformatf("v%0d.ready0", i), req0_ready24, vecs[i].rdy0);
      chk($sformatf("v%0d.ready1", i), req1_ready24, vecs[i].rdy1);
      chk_apb($sformatf("v%0d", i), vecs[i].psel, vecs[i].pen);
      chk($sformatf("v%0d.pwrite", i), pwrite24, vecs[i].pwr);
      chk($sformatf("v%0d.paddr", i), paddr24, vecs[i].paddr);
      chk($sformatf("v%0d.pwdata", i), pwdata24, vecs[i].pwdata);
      chk($sformatf("v%0d.rvalid0", i), req0_rvalid24, vecs[i].rv0);
      chk($sformatf("v%0d.rvalid1", i), req1_rvalid24, vecs[i].rv1);
      chk($sformatf("v%0d.rdata", i), req_rdata24, vecs[i].rdata);
    end

    // Stall: req0 arrives while a req1 read sits in SETUP and must wait for ACCESS
    @(posedge pclk24);
    #1 drive(0,0,0,0, 1,0,6'h3C,0, 0);
    @(negedge pclk24);
    chk("stall.grant1", req1_ready24, 1'b1);
    @(posedge pclk24);
    #1 drive(1,1,6'h0C,32'h55, 0,0,0,0, 0);
    @(negedge pclk24);
    chk("stall.setup_ready0", req0_ready24, 1'b0);
    chk_apb("stall.setup", 1'b1, 1'b0);
    chk("stall.setup_paddr", paddr24, 6'h3C);
    @(posedge pclk24);
    #1 prdata24 = 32'h200;
    @(negedge pclk24);
    chk("stall.access_ready0", req0_ready24, 1'b1);
    chk_apb("stall.access", 1'b1, 1'b1);
    @(posedge pclk24);
    #1 drive(0,0,0,0, 0,0,0,0, 0);
    @(negedge pclk24);
    chk_apb("stall.setup2", 1'b1, 1'b0);
    chk("stall.held_paddr", paddr24, 6'h0C);
    chk("stall.held_pwdata", pwdata24, 32'h55);
    chk("stall.held_pwrite", pwrite24, 1'b1);
    chk("stall.rvalid1", req1_rvalid24, 1'b1);
    chk("stall.rdata", req_rdata24, 32'h200);
    repeat (2) @(posedge pclk24);
    @(negedge pclk24);
    chk_apb("stall.idle", 1'b0, 1'b0);
    chk("stall.rvalid0", req0_rvalid24, 1'b0);

    // Reset during ACCESS of a req0 read: drop strobes at once, no rvalid, pointer back to req0
    @(posedge pclk24);
    #1 drive(1,0,6'h08,0, 0,0,0,0, 0);
    @(negedge pclk24);
    chk("rsta.grant0", req0_ready24, 1'b1);
    @(posedge pclk24);
    #1 drive(0,0,0,0, 0,0,0,0, 0);
    @(posedge pclk24);
    #1 prdata24 = 32'h300;
    @(negedge pclk24);
    chk_apb("rsta.access", 1'b1, 1'b1);
    #1 n_p_reset24 = 1'b0;
    drive(1,1,6'h2A,32'h9, 0,0,0,0, 32'h300);
    #1;
    chk_apb("rsta.now", 1'b0, 1'b0);
    chk("rsta.ready0", req0_ready24, 1'b0);
    chk("rsta.paddr", paddr24, 6'h00);
    chk("rsta.rdata", req_rdata24, 32'h0);
    @(negedge pclk24);
    chk("rsta.rvalid0", req0_rvalid24, 1'b0);
    chk("rsta.ready0_hold", req0_ready24, 1'b0);
    @(posedge pclk24);
    #1 n_p_reset24 = 1'b1;
    req1_valid24 = 1'b1;
    @(negedge pclk24);
    chk_apb("rsta.idle", 1'b0, 1'b0);
    chk("rsta.ptr_ready0", req0_ready24, 1'b1);
    chk("rsta.ptr_ready1", req1_ready24, 1'b0);
    chk("rsta.no_rvalid0", req0_rvalid24, 1'b0);
    chk("rsta.no_rvalid1", req1_rvalid24, 1'b0);
    @(posedge pclk24);
    #1 drive(0,0,0,0, 0,0,0,0, 0);
    repeat (3) begin
      @(negedge pclk24);
      chk("rsta.after_rvalid0", req0_rvalid24, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
